// File: rtl/sprite_pkg.sv
// Shared types, widths and reset tables for the sprite motion controller.
package sprite_pkg;
  localparam int N_SPRITES_DEFAULT = 4;
  localparam int H_ACTIVE_DEFAULT  = 1600;
  localparam int V_ACTIVE_DEFAULT  = 1200;
  localparam int ROW_W  = 11;
  localparam int COL_W  = 12;
  localparam int VEL_W  = 5;
  localparam int CALC_W = 13;
  localparam int N_RST  = 4;

  typedef enum logic [1:0] {IDLE, CALC, COMMIT, DONE} state_e;

  // Sprites beyond the fourth reuse the table cyclically.
  localparam logic [ROW_W-1:0] RST_ROW [N_RST] = '{11'd300, 11'd500, 11'd900, 11'd1000};
  localparam logic [COL_W-1:0] RST_COL [N_RST] = '{12'd300, 12'd600, 12'd1000, 12'd1300};
  localparam logic signed [VEL_W-1:0] RST_VX [N_RST] = '{5'sd3, -5'sd5, 5'sd7, -5'sd2};
  localparam logic signed [VEL_W-1:0] RST_VY [N_RST] = '{5'sd2, 5'sd4, -5'sd6, -5'sd3};
endpackage

// File: rtl/sprite_motion_ctrl_axis_step.sv
// One-axis motion step: advance position by velocity, clamp to [lo, hi] and
// reflect the velocity when a wall is hit.
module axis_step
  import sprite_pkg::*;
#(
  parameter int POS_W = COL_W
) (
  input  logic [POS_W-1:0]         pos,
  input  logic signed [VEL_W-1:0]  vel,
  input  logic signed [CALC_W-1:0] lo,
  input  logic signed [CALC_W-1:0] hi,
  output logic [POS_W-1:0]         pos_out,
  output logic signed [VEL_W-1:0]  vel_out
);
  // The most negative velocity has no positive twin; pin it to the max.
  function automatic logic signed [VEL_W-1:0] neg_sat(input logic signed [VEL_W-1:0] v);
    if (v == {1'b1, {(VEL_W-1){1'b0}}}) return {1'b0, {(VEL_W-1){1'b1}}};
    return -v;
  endfunction

  logic signed [CALC_W-1:0] pos_s;
  logic signed [CALC_W-1:0] vel_s;
  logic signed [CALC_W-1:0] nxt;
  logic signed [CALC_W-1:0] clamped;

  always_comb begin
    pos_s   = $signed({{(CALC_W-POS_W){1'b0}}, pos});
    vel_s   = $signed({{(CALC_W-VEL_W){vel[VEL_W-1]}}, vel});
    nxt     = pos_s + vel_s;
    clamped = nxt;
    vel_out = vel;
    if (nxt < lo) begin
      clamped = lo;
      vel_out = neg_sat(vel);
    end else if (nxt > hi) begin
      clamped = hi;
      vel_out = neg_sat(vel);
    end
    pos_out = POS_W'(clamped);
  end
endmodule

// File: rtl/sprite_motion_ctrl.sv
// Per-frame sprite position sequencer: one CALC/COMMIT pair per sprite.
// Optional build macro GRAVITY_EN adds +1 to vy on every commit.
module sprite_motion_ctrl
  import sprite_pkg::*;
#(
  parameter int N_SPRITES = N_SPRITES_DEFAULT,
  parameter int H_ACTIVE  = H_ACTIVE_DEFAULT,
  parameter int V_ACTIVE  = V_ACTIVE_DEFAULT
) (
  input  logic                                 clock_162,
  input  logic                                 rst,
  input  logic                                 frame_start,
  input  logic                                 run,
  input  logic [5:0]                           radius,
  output logic [N_SPRITES-1:0][ROW_W-1:0]      sprite_row,
  output logic [N_SPRITES-1:0][COL_W-1:0]      sprite_col,
  output logic                                 busy,
  output logic                                 update_done
);
  localparam int IDX_W = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SPRITES - 1);
  localparam logic signed [CALC_W-1:0] COL_MAX = CALC_W'(H_ACTIVE - 1);
  localparam logic signed [CALC_W-1:0] ROW_MAX = CALC_W'(V_ACTIVE - 1);

  state_e state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [5:0]       radius_q, radius_d;
  logic [N_SPRITES-1:0][ROW_W-1:0] row_q, row_d;
  logic [N_SPRITES-1:0][COL_W-1:0] col_q, col_d;
  logic [N_SPRITES-1:0][VEL_W-1:0] vx_q, vx_d, vy_q, vy_d;
  logic [COL_W-1:0]        ncol_q, ncol_d, col_step;
  logic [ROW_W-1:0]        nrow_q, nrow_d, row_step;
  logic signed [VEL_W-1:0] nvx_q, nvx_d, vx_step;
  logic signed [VEL_W-1:0] nvy_q, nvy_d, vy_step, vy_wr;
  logic signed [CALC_W-1:0] lo_b, col_hi, row_hi;
  logic start;

  assign start = frame_start & run;

`ifdef GRAVITY_EN
  function automatic logic signed [VEL_W-1:0] vel_inc_sat(input logic signed [VEL_W-1:0] v);
    if (v == {1'b0, {(VEL_W-1){1'b1}}}) return v;
    return v + {{(VEL_W-1){1'b0}}, 1'b1};
  endfunction
  assign vy_wr = vel_inc_sat(nvy_q);
`else
  assign vy_wr = nvy_q;
`endif

  always_comb begin
    lo_b   = $signed({{(CALC_W-6){1'b0}}, radius_q});
    col_hi = COL_MAX - lo_b;
    row_hi = ROW_MAX - lo_b;
  end

  axis_step #(.POS_W(COL_W)) u_col_step (
    .pos(col_q[idx_q]), .vel($signed(vx_q[idx_q])), .lo(lo_b), .hi(col_hi),
    .pos_out(col_step), .vel_out(vx_step)
  );

  axis_step #(.POS_W(ROW_W)) u_row_step (
    .pos(row_q[idx_q]), .vel($signed(vy_q[idx_q])), .lo(lo_b), .hi(row_hi),
    .pos_out(row_step), .vel_out(vy_step)
  );

  always_ff @(posedge clock_162 or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    state_d = COMMIT;
      COMMIT:  state_d = (idx_q == LAST_IDX) ? DONE : CALC;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q != IDLE);
    update_done = (state_q == DONE);
  end

  always_comb begin
    idx_d    = idx_q;
    radius_d = radius_q;
    row_d    = row_q;
    col_d    = col_q;
    vx_d     = vx_q;
    vy_d     = vy_q;
    ncol_d   = ncol_q;
    nrow_d   = nrow_q;
    nvx_d    = nvx_q;
    nvy_d    = nvy_q;
    case (state_q)
      IDLE: if (start) begin
        idx_d    = '0;
        radius_d = radius;
      end
      CALC: begin
        ncol_d = col_step;
        nrow_d = row_step;
        nvx_d  = vx_step;
        nvy_d  = vy_step;
      end
      COMMIT: begin
        col_d[idx_q] = ncol_q;
        row_d[idx_q] = nrow_q;
        vx_d[idx_q]  = nvx_q;
        vy_d[idx_q]  = vy_wr;
        if (idx_q != LAST_IDX) idx_d = idx_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock_162 or posedge rst) begin
    if (rst) begin
      idx_q    <= '0;
      radius_q <= '0;
      for (int i = 0; i < N_SPRITES; i++) begin
        row_q[i] <= RST_ROW[i % N_RST];
        col_q[i] <= RST_COL[i % N_RST];
        vx_q[i]  <= RST_VX[i % N_RST];
        vy_q[i]  <= RST_VY[i % N_RST];
      end
    end else begin
      idx_q    <= idx_d;
      radius_q <= radius_d;
      row_q    <= row_d;
      col_q    <= col_d;
      vx_q     <= vx_d;
      vy_q     <= vy_d;
    end
  end

  // CALC -> COMMIT staging of the stepped values; consumed only in COMMIT.
  always_ff @(posedge clock_162) begin
    ncol_q <= ncol_d;
    nrow_q <= nrow_d;
    nvx_q  <= nvx_d;
    nvy_q  <= nvy_d;
  end

  assign sprite_row = row_q;
  assign sprite_col = col_q;
endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Directed bench for sprite_motion_ctrl with hand-computed expectations.
module tb_sprite_motion_ctrl;
  logic clock_162 = 1'b0;
  logic rst = 1'b1;
  logic frame_start = 1'b0;
  logic run = 1'b0;
  logic [5:0] radius = 6'd10;
  logic [3:0][10:0] sprite_row;
  logic [3:0][11:0] sprite_col;
  logic busy;
  logic update_done;

  int n_cmp = 0;
  int n_bad = 0;

  sprite_motion_ctrl dut (
    .clock_162(clock_162), .rst(rst), .frame_start(frame_start), .run(run),
    .radius(radius), .sprite_row(sprite_row), .sprite_col(sprite_col),
    .busy(busy), .update_done(update_done)
  );

  always #5 clock_162 = ~clock_162;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock_162);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    frame_start = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
  endtask

  task automatic run_frame();
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
    for (int k = 0; k < 30 && !update_done; k++) cyc();
    if (!update_done) chk("frame_timeout", 0, 1);
    cyc();
  endtask

  initial begin
    int first_done;
    int n_done;
    int busy_seen;
    int v;

    // Reset state
    do_reset();
    chk("rst_busy", busy, 0);
    chk("rst_done", update_done, 0);
    chk("rst_row0", sprite_row[0], 300);
    chk("rst_row3", sprite_row[3], 1000);
    chk("rst_col0", sprite_col[0], 300);
    chk("rst_col2", sprite_col[2], 1000);

    // First pass, with a second frame_start that must be ignored
    run = 1'b1;
    radius = 6'd10;
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
    first_done = 0;
    n_done = 0;
    for (int c = 1; c <= 14; c++) begin
      if (c == 1) chk("busy_c1", busy, 1);
      if (update_done) begin
        n_done++;
        if (first_done == 0) first_done = c;
      end
      if (c == 3) frame_start = 1'b1;
      if (c == 4) frame_start = 1'b0;
      if (c == 10) chk("busy_c10", busy, 0);
      cyc();
    end
    chk("done_latency", first_done, 9);
    chk("done_count", n_done, 1);
    chk("p1_col0", sprite_col[0], 303);
    chk("p1_row0", sprite_row[0], 302);
    chk("p1_col1", sprite_col[1], 595);
    chk("p1_row1", sprite_row[1], 504);
    chk("p1_col2", sprite_col[2], 1007);
    chk("p1_row2", sprite_row[2], 894);
    chk("p1_col3", sprite_col[3], 1298);
    chk("p1_row3", sprite_row[3], 997);

    // run=0: pulses ignored, positions frozen, new radius not picked up
    run = 1'b0;
    radius = 6'd63;
    busy_seen = 0;
    for (int p = 0; p < 5; p++) begin
      frame_start = 1'b1;
      cyc();
      if (busy) busy_seen = 1;
      frame_start = 1'b0;
      cyc();
      if (busy) busy_seen = 1;
    end
    chk("run0_busy", busy_seen, 0);
    chk("run0_col0", sprite_col[0], 303);
    chk("run0_row2", sprite_row[2], 894);

    // Asynchronous reset during COMMIT of sprite 2 (cycle 6 of the pass)
    run = 1'b1;
    radius = 6'd10;
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
    for (int c = 1; c < 6; c++) cyc();
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", update_done, 0);
    chk("mid_rst_col0", sprite_col[0], 300);
    chk("mid_rst_row0", sprite_row[0], 300);
    chk("mid_rst_col1", sprite_col[1], 600);
    chk("mid_rst_row1", sprite_row[1], 500);
    chk("mid_rst_col3", sprite_col[3], 1300);
    cyc();
    rst = 1'b0;
    cyc();

    // Long run: low wall bounce on sprite 1, high wall bounce on sprite 0
    radius = 6'd10;
    for (int f = 1; f <= 431; f++) begin
      run_frame();
      if (f == 118) chk("f118_col1", sprite_col[1], 10);
      if (f == 119) chk("f119_col1", sprite_col[1], 10);
      if (f == 120) chk("f120_col1", sprite_col[1], 15);
      if (f == 429) chk("f429_col0", sprite_col[0], 1587);
      if (f == 430) begin
        chk("f430_col0", sprite_col[0], 1589);
        v = $signed(dut.vx_q[0]);
        chk("f430_vx0", v, -3);
      end
      if (f == 431) chk("f431_col0", sprite_col[0], 1586);
    end

    // Vertical velocity update over two frames
    do_reset();
    run_frame();
    chk("g1_row0", sprite_row[0], 302);
    v = $signed(dut.vy_q[0]);
`ifdef GRAVITY_EN
    chk("g1_vy0", v, 3);
`else
    chk("g1_vy0", v, 2);
`endif
    run_frame();
    v = $signed(dut.vy_q[0]);
`ifdef GRAVITY_EN
    chk("g2_row0", sprite_row[0], 305);
    chk("g2_vy0", v, 4);
`else
    chk("g2_row0", sprite_row[0], 304);
    chk("g2_vy0", v, 2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
